// File: rtl/trivium_keystream_gen.sv
// trivium_keystream_gen
// Byte-wide Trivium keystream generator. Takes an 80-bit key and an 80-bit
// IV as 20 bytes, runs WARMUP_BITS warm-up steps, and then delivers one
// keystream byte per cycle over a valid/ready port.
// Optional feature macro: TRIVIUM_KS_COUNT_EN adds a saturating 16-bit count
// (ks_count) of completed keystream handshakes.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_LOAD | accepting key bytes 0-9, then IV bytes 10-19
//   ST_INIT | warm-up: 8 discarded steps per cycle, busy=1
//   ST_RUN  | producing keystream bytes, 8 steps per accepted byte
module trivium_keystream_gen #(
  parameter int WARMUP_BITS = 1152
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  output logic [7:0] ks_data,
  output logic       ks_valid,
  input  logic       ks_ready,
  input  logic       rekey,
`ifdef TRIVIUM_KS_COUNT_EN
  output logic [15:0] ks_count,
`endif
  output logic       busy
);

  localparam int INIT_CYCLES = WARMUP_BITS / 8;
  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_INIT,
    ST_RUN
  } state_t;

  state_t         state;
  logic [287:0]   st_q;        // st_q[n-1] holds Trivium bit s_n
  logic [151:0]   key_iv_q;    // first 19 bytes; byte 19 arrives live
  logic [4:0]     byte_cnt_q;
  logic [CW-1:0]  init_cnt_q;  // warm-up cycles left, terminal count at 0
  logic [7:0]     step_z;
  logic [287:0]   step_s;

`ifdef TRIVIUM_KS_COUNT_EN
  logic [15:0]    ks_count_q;
  assign ks_count = ks_count_q;
`endif

  // Eight chained Trivium steps; the first keystream bit lands in bit 7.
  function automatic logic [295:0] step8(input logic [287:0] s_in);
    logic [287:0] s;
    logic [7:0]   zb;
    logic         t1, t2, t3;
    s  = s_in;
    zb = '0;
    for (int i = 0; i < 8; i++) begin
      t1 = s[65]  ^ s[92];
      t2 = s[161] ^ s[176];
      t3 = s[242] ^ s[287];
      zb = {zb[6:0], t1 ^ t2 ^ t3};
      t1 = t1 ^ (s[90]  & s[91])  ^ s[170];
      t2 = t2 ^ (s[174] & s[175]) ^ s[263];
      t3 = t3 ^ (s[285] & s[286]) ^ s[68];
      s  = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    return {zb, s};
  endfunction

  // Initial state from the 20 loaded bytes; kv[159] is key bit K1.
  function automatic logic [287:0] seed(input logic [159:0] kv);
    logic [287:0] r;
    r = '0;
    for (int n = 1; n <= 80; n++) begin
      r[n-1]  = kv[160-n];
      r[92+n] = kv[80-n];
    end
    r[287:285] = 3'b111;
    return r;
  endfunction

  // Shared step network used by both warm-up and keystream production.
  always_comb {step_z, step_s} = step8(st_q);

  // Control FSM, cipher state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst || rekey) begin
      // rekey behaves as a reset of the stream; rst simply wins when both are high
      state      <= ST_LOAD;
      st_q       <= '0;
      key_iv_q   <= '0;
      byte_cnt_q <= '0;
      init_cnt_q <= '0;
      ks_data    <= '0;
      ks_valid   <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
`ifdef TRIVIUM_KS_COUNT_EN
      ks_count_q <= '0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_valid) begin
            key_iv_q <= {key_iv_q[143:0], load_data};
            if (byte_cnt_q == 5'd19) begin
              st_q       <= seed({key_iv_q, load_data});
              byte_cnt_q <= '0;
              init_cnt_q <= CW'(INIT_CYCLES - 1);
              busy       <= 1'b1;
              load_ready <= 1'b0;
              state      <= ST_INIT;
`ifdef TRIVIUM_KS_COUNT_EN
              ks_count_q <= '0;
`endif
            end else begin
              byte_cnt_q <= byte_cnt_q + 5'd1;
            end
          end
        end
        ST_INIT: begin
          st_q <= step_s;
          if (init_cnt_q == '0) begin
            busy  <= 1'b0;
            state <= ST_RUN;
          end else begin
            init_cnt_q <= init_cnt_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!ks_valid || ks_ready) begin
            st_q     <= step_s;
            ks_data  <= step_z;
            ks_valid <= 1'b1;
          end
`ifdef TRIVIUM_KS_COUNT_EN
          if (ks_valid && ks_ready && ks_count_q != 16'hffff)
            ks_count_q <= ks_count_q + 16'd1;
`endif
        end
        default: begin
          state      <= ST_LOAD;
          load_ready <= 1'b1;
          busy       <= 1'b0;
          ks_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Testbench for trivium_keystream_gen: random and directed key/IV loads
// compared against a bit-serial Trivium model written from the algorithm.
module tb_trivium_keystream_gen;

  localparam int WARMUP_BITS = 1152;
  localparam int INIT_CYCLES = WARMUP_BITS / 8;

  logic       clk;
  logic       rst;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] ks_data;
  logic       ks_valid;
  logic       ks_ready;
  logic       rekey;
  logic       busy;
`ifdef TRIVIUM_KS_COUNT_EN
  logic [15:0] ks_count;
`endif

  trivium_keystream_gen #(.WARMUP_BITS(WARMUP_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_data (load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .ks_data   (ks_data),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .rekey     (rekey),
`ifdef TRIVIUM_KS_COUNT_EN
    .ks_count  (ks_count),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] kiv [20];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic [7:0] first_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: state s[1..288] indexed exactly as the algorithm text.
  task automatic model_gen(input int nbytes);
    bit s [1:288];
    bit t1, t2, t3, z;
    logic [7:0] b;
    b = '0;
    for (int k = 1; k <= 288; k++) s[k] = 1'b0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 8; j++) begin
        s[8*i+1+j]    = kiv[i][7-j];
        s[93+8*i+1+j] = kiv[10+i][7-j];
      end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    exp_q.delete();
    for (int n = 0; n < WARMUP_BITS + 8*nbytes; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int k = 93; k >= 2; k--) s[k] = s[k-1];
      s[1] = t3;
      for (int k = 177; k >= 95; k--) s[k] = s[k-1];
      s[94] = t1;
      for (int k = 288; k >= 179; k--) s[k] = s[k-1];
      s[178] = t2;
      if (n >= WARMUP_BITS) begin
        b = {b[6:0], z};
        if ((n - WARMUP_BITS) % 8 == 7) exp_q.push_back(b);
      end
    end
  endtask

  // Presents kiv[0..19] back-to-back; returns 1 time unit after the accepting edge of byte 19.
  task automatic load20();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      load_data  = kiv[i];
      load_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic do_rekey();
    rekey = 1'b1;
    @(posedge clk);
    #1;
    rekey = 1'b0;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!ks_valid && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("wait_valid_timeout", 32'(g < 400), 32'd1);
  endtask

  // Collects n bytes via handshakes; with rnd, ks_ready toggles randomly and held bytes must not change.
  task automatic collect(input int n, input bit rnd);
    int guard;
    bit stall;
    logic [7:0] held;
    got_q.delete();
    guard = 0;
    stall = 1'b0;
    held  = '0;
    while (got_q.size() < n && guard < 5000) begin
      if (stall) check("bp_stable", {23'd0, ks_valid, ks_data}, {23'd0, 1'b1, held});
      ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ks_valid && ks_ready) got_q.push_back(ks_data);
      stall = ks_valid && !ks_ready;
      held  = ks_data;
      @(posedge clk);
      #1;
      guard++;
    end
    ks_ready = 1'b0;
    check("collect_timeout", 32'(guard < 5000), 32'd1);
  endtask

  task automatic compare_stream(input string tag, input int offset, input int n);
    for (int i = 0; i < n && i < got_q.size() && offset + i < exp_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp_q[offset + i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_ks_valid"},   32'(ks_valid),   32'd0);
    check({tag, "_ks_data"},    32'(ks_data),    32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    int bcnt;
    int first;
    logic [7:0] pt [4];
    logic [7:0] ct [4];

    rst = 1'b1; rekey = 1'b0; load_data = '0; load_valid = 1'b0; ks_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // zero key and IV: warm-up timing plus first 64 bytes
    for (int i = 0; i < 20; i++) kiv[i] = 8'h00;
    model_gen(64);
    ks_ready = 1'b1;
    load20();
    bcnt  = 0;
    first = -1;
    for (int e = 0; e < 400; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) bcnt++;
      if (ks_valid) begin
        first = e;
        break;
      end
    end
    check("busy_cycles", 32'(bcnt), 32'(INIT_CYCLES));
    check("first_valid_edge", 32'(first), 32'(INIT_CYCLES + 1));
    collect(64, 1'b0);
    compare_stream("zero_ks", 0, 64);

    // determinism across rekey, and XOR round trip between the two runs
    for (int i = 0; i < 10; i++) kiv[i] = 8'(i + 1);
    kiv[10] = 8'h76;
    for (int i = 11; i < 20; i++) kiv[i] = 8'h00;
    model_gen(16);
    do_rekey();
    load20();
    wait_valid();
    collect(16, 1'b0);
    compare_stream("det_run1", 0, 16);
    first_q = got_q;
    do_rekey();
    load20();
    wait_valid();
    collect(16, 1'b0);
    for (int i = 0; i < 16 && i < got_q.size() && i < first_q.size(); i++)
      check("det_repeat", 32'(got_q[i]), 32'(first_q[i]));
    pt[0] = 8'hDE; pt[1] = 8'hAD; pt[2] = 8'hBE; pt[3] = 8'hEF;
    for (int i = 0; i < 4 && i < first_q.size() && i < got_q.size(); i++) begin
      ct[i] = pt[i] ^ first_q[i];
      check("xor_roundtrip", 32'(ct[i] ^ got_q[i]), 32'(pt[i]));
    end

    // random key/IV with explicit 5-cycle stall and random backpressure
    for (int i = 0; i < 20; i++) kiv[i] = 8'($urandom);
    model_gen(40);
    do_rekey();
    load20();
    wait_valid();
    collect(8, 1'b0);
    compare_stream("rnd_ks", 0, 8);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold", {23'd0, ks_valid, ks_data}, {23'd0, 1'b1, exp_q[8]});
      @(posedge clk);
      #1;
    end
    collect(8, 1'b0);
    compare_stream("bp_release", 8, 8);
    collect(24, 1'b1);
    compare_stream("rnd_ready", 16, 24);

    // rekey on load byte 7: byte dropped, counter restarts
    do_rekey();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      load_data  = 8'($urandom);
      load_valid = 1'b1;
    end
    @(negedge clk);
    load_data  = 8'($urandom);
    load_valid = 1'b1;
    rekey      = 1'b1;
    @(posedge clk);
    #1;
    rekey      = 1'b0;
    load_valid = 1'b0;
    check("abort_load_ready", 32'(load_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) kiv[i] = 8'($urandom);
    model_gen(8);
    load20();
    wait_valid();
    collect(8, 1'b0);
    compare_stream("reload_ks", 0, 8);

    // rekey at INIT cycle 50
    do_rekey();
    load20();
    repeat (50) @(posedge clk);
    #1;
    check("init_busy", 32'(busy), 32'd1);
    rekey = 1'b1;
    @(posedge clk);
    #1;
    rekey = 1'b0;
    check("init_abort_busy", 32'(busy), 32'd0);
    check("init_abort_load_ready", 32'(load_ready), 32'd1);
    check("init_abort_ks_valid", 32'(ks_valid), 32'd0);

    // rst during RUN
    load20();
    wait_valid();
    collect(3, 1'b0);
    compare_stream("pre_rst_ks", 0, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("run_rst");

`ifdef TRIVIUM_KS_COUNT_EN
    load20();
    wait_valid();
    collect(10, 1'b0);
    check("count_10", 32'(ks_count), 32'd10);
    do_rekey();
    check("count_rekey", 32'(ks_count), 32'd0);
    load20();
    wait_valid();
    force dut.ks_count_q = 16'hfffe;
    @(posedge clk);
    #1;
    release dut.ks_count_q;
    collect(3, 1'b0);
    check("count_saturate", 32'(ks_count), 32'h0000ffff);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
